// File: rtl/sprite_pkg.sv
// Shared types and constants for the ball/trail sprite renderer.
package sprite_pkg;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {WAIT_FRAME, RUN} render_state_t;

    localparam logic [23:0] BallColor  = 24'hFF5500;
    localparam logic [23:0] TrailColor = 24'h00AAFF;
    localparam logic [23:0] BgColor    = 24'h000000;

    localparam logic [9:0] ScreenW = 10'd640;
    localparam logic [9:0] ScreenH = 10'd480;

    // Older trail entries get dimmer: each channel halves per frame of age.
    function automatic rgb_t fade_rgb(input rgb_t c, input logic [2:0] age);
        rgb_t f;
        f.r = c.r >> age;
        f.g = c.g >> age;
        f.b = c.b >> age;
        return f;
    endfunction

endpackage

// File: rtl/ball_trail_render_if.sv
// Pixel/motion bus between the motion stage, VGA controller and the trail renderer.
interface ball_trail_render_if;
    logic       VS;
    logic       Freeze;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       ball_on;
    logic       trail_on;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;

    modport master (
        output VS, Freeze, BallX, BallY, BallS, DrawX, DrawY,
        input  ball_on, trail_on, Red, Green, Blue
    );

    modport slave (
        input  VS, Freeze, BallX, BallY, BallS, DrawX, DrawY,
        output ball_on, trail_on, Red, Green, Blue
    );
endinterface

// File: rtl/trail_ring.sv
// Ring buffer of past ball positions with write pointer, fill count and per-slot age/valid.
module trail_ring
    import sprite_pkg::*;
#(
    parameter int unsigned TRAIL_LEN = 4,
    localparam int unsigned PtrW = $clog2(TRAIL_LEN)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  pos_t                 wr_pos_i,
    output pos_t                 pos_o   [TRAIL_LEN],
    output logic [TRAIL_LEN-1:0] valid_o,
    output logic [PtrW-1:0]      age_o   [TRAIL_LEN]
);

    pos_t          ring_q [TRAIL_LEN];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TRAIL_LEN; i++) ring_q[i] <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (wr_en_i) begin
            ring_q[wr_ptr_q] <= wr_pos_i;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
            if (count_q != (PtrW+1)'(TRAIL_LEN)) count_q <= count_q + 1'b1;
        end
    end

    // Power-of-two length lets the pointer arithmetic wrap naturally.
    always_comb begin
        for (int i = 0; i < TRAIL_LEN; i++) begin
            pos_o[i]   = ring_q[i];
            age_o[i]   = wr_ptr_q - PtrW'(1) - PtrW'(i);
            valid_o[i] = {1'b0, age_o[i]} < count_q;
        end
    end

endmodule

// File: rtl/ball_trail_render.sv
// Ball + motion-trail renderer with a fixed 2-cycle pixel pipeline.
// Optional build macro TRAIL_FADE_EN: dims each trail marker by its age.
module ball_trail_render
    import sprite_pkg::*;
#(
    parameter int unsigned TRAIL_LEN   = 4,
    parameter int unsigned TRAIL_HALF  = 2,
    parameter logic [23:0] BALL_COLOR  = BallColor,
    parameter logic [23:0] TRAIL_COLOR = TrailColor,
    parameter logic [23:0] BG_COLOR    = BgColor
) (
    input logic                Clk,
    input logic                Reset,
    ball_trail_render_if.slave bus
);

    localparam int unsigned      PtrW = $clog2(TRAIL_LEN);
    localparam logic signed [10:0] Half = 11'(TRAIL_HALF);

    logic          vs_q, frame_start;
    render_state_t state_q, state_d;
    logic          snap_load, ring_wr, render_en;
    pos_t          snap_q;
    logic [9:0]    snap_s_q;

    pos_t                 ring_pos [TRAIL_LEN];
    logic [TRAIL_LEN-1:0] ring_valid;
    logic [PtrW-1:0]      ring_age [TRAIL_LEN];

    assign frame_start = vs_q & ~bus.VS;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q     <= 1'b1;
            state_q  <= WAIT_FRAME;
            snap_q   <= '0;
            snap_s_q <= '0;
        end else begin
            vs_q    <= bus.VS;
            state_q <= state_d;
            if (snap_load) begin
                snap_q   <= '{x: bus.BallX, y: bus.BallY};
                snap_s_q <= bus.BallS;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_FRAME: if (frame_start) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    // The first frame only primes the snapshot; Freeze is ignored there.
    always_comb begin
        snap_load = 1'b0;
        ring_wr   = 1'b0;
        render_en = 1'b0;
        unique case (state_q)
            WAIT_FRAME: snap_load = frame_start;
            RUN: begin
                snap_load = frame_start & ~bus.Freeze;
                ring_wr   = frame_start & ~bus.Freeze;
                render_en = 1'b1;
            end
            default: ;
        endcase
    end

    trail_ring #(
        .TRAIL_LEN(TRAIL_LEN)
    ) u_ring (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .wr_en_i (ring_wr),
        .wr_pos_i(snap_q),
        .pos_o   (ring_pos),
        .valid_o (ring_valid),
        .age_o   (ring_age)
    );

    // Stage 1: ball offsets and youngest trail-box hit.
    logic signed [10:0]   dx_s, dy_s;
    logic signed [10:0]   tdx [TRAIL_LEN];
    logic signed [10:0]   tdy [TRAIL_LEN];
    logic [TRAIL_LEN-1:0] thit;
    logic                 any_hit, vis;
    logic [PtrW-1:0]      best_age;

    always_comb begin
        dx_s     = $signed({1'b0, bus.DrawX}) - $signed({1'b0, snap_q.x});
        dy_s     = $signed({1'b0, bus.DrawY}) - $signed({1'b0, snap_q.y});
        vis      = (bus.DrawX < ScreenW) && (bus.DrawY < ScreenH);
        any_hit  = 1'b0;
        best_age = '0;
        for (int i = 0; i < TRAIL_LEN; i++) begin
            tdx[i]  = $signed({1'b0, bus.DrawX}) - $signed({1'b0, ring_pos[i].x});
            tdy[i]  = $signed({1'b0, bus.DrawY}) - $signed({1'b0, ring_pos[i].y});
            thit[i] = ring_valid[i] && (tdx[i] >= -Half) && (tdx[i] <= Half)
                      && (tdy[i] >= -Half) && (tdy[i] <= Half);
            if (thit[i] && (!any_hit || ring_age[i] < best_age)) begin
                any_hit  = 1'b1;
                best_age = ring_age[i];
            end
        end
    end

    logic               en1_q, thit1_q;
    logic signed [10:0] dx1_q, dy1_q;
    logic [9:0]         s1_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            en1_q   <= 1'b0;
            thit1_q <= 1'b0;
            dx1_q   <= '0;
            dy1_q   <= '0;
            s1_q    <= '0;
        end else begin
            en1_q   <= render_en && vis;
            thit1_q <= any_hit;
            dx1_q   <= dx_s;
            dy1_q   <= dy_s;
            s1_q    <= snap_s_q;
        end
    end

`ifdef TRAIL_FADE_EN
    logic [PtrW-1:0] tage1_q;
    always_ff @(posedge Clk) begin
        if (Reset) tage1_q <= '0;
        else       tage1_q <= best_age;
    end
`endif

    // Stage 2: disc test and colour select.
    logic signed [21:0] dxw, dyw;
    logic [21:0]        sq_x, sq_y, sq_s;
    logic               ball_hit, trail_hit;
    rgb_t               trail_rgb, pix_rgb;

    always_comb begin
        dxw       = {{11{dx1_q[10]}}, dx1_q};
        dyw       = {{11{dy1_q[10]}}, dy1_q};
        sq_x      = dxw * dxw;
        sq_y      = dyw * dyw;
        sq_s      = {12'b0, s1_q} * {12'b0, s1_q};
        ball_hit  = en1_q && ((sq_x + sq_y) <= sq_s);
        trail_hit = en1_q && thit1_q && !ball_hit;
`ifdef TRAIL_FADE_EN
        trail_rgb = fade_rgb(rgb_t'(TRAIL_COLOR), 3'(tage1_q));
`else
        trail_rgb = rgb_t'(TRAIL_COLOR);
`endif
        if (ball_hit)       pix_rgb = rgb_t'(BALL_COLOR);
        else if (trail_hit) pix_rgb = trail_rgb;
        else                pix_rgb = rgb_t'(BG_COLOR);
    end

    logic ball_on_q, trail_on_q;
    rgb_t rgb_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ball_on_q  <= 1'b0;
            trail_on_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            ball_on_q  <= ball_hit;
            trail_on_q <= trail_hit;
            rgb_q      <= pix_rgb;
        end
    end

    assign bus.ball_on  = ball_on_q;
    assign bus.trail_on = trail_on_q;
    assign bus.Red      = rgb_q.r;
    assign bus.Green    = rgb_q.g;
    assign bus.Blue     = rgb_q.b;

endmodule
